// File: rtl/cpu.sv
// Multi-cycle 16-bit CPU: 4-entry register file (x0 hardwired to zero), one shared
// single-port instruction/data memory, and a FETCH/DECODE/EXEC/MEM/WB sequencer.

module cpu_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [1:0]  i_wa,
  input  logic [15:0] i_wd,
  input  logic [1:0]  i_ra1,
  input  logic [1:0]  i_ra2,
  input  logic [1:0]  i_ra3,
  output logic [15:0] o_rd1,
  output logic [15:0] o_rd2,
  output logic [15:0] o_rd3
);
  logic [15:0] x1, x2, x3;
  logic [15:0] w_x [4];

  assign w_x[0] = '0;
  assign w_x[1] = x1;
  assign w_x[2] = x2;
  assign w_x[3] = x3;
  assign o_rd1  = w_x[i_ra1];
  assign o_rd2  = w_x[i_ra2];
  assign o_rd3  = w_x[i_ra3];

  always_ff @(posedge clk) begin
    if (!reset) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
    end else if (i_we) begin
      case (i_wa)
        2'd1:    x1 <= i_wd;
        2'd2:    x2 <= i_wd;
        2'd3:    x3 <= i_wd;
        default: ;
      endcase
    end
  end
endmodule

module cpu_mem #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wd,
  output logic [15:0]   o_rd
);
  logic [15:0] memory [DEPTH];

  // Read-first single port; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) memory[i_addr] <= i_wd;
    o_rd <= memory[i_addr];
  end
endmodule

module cpu #(
  parameter int MEM_DEPTH = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD, OP_STORE, OP_NOP, OP_HALT
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ea;
  logic [15:0]   r_ir;
  logic [15:0]   r_res;
  logic          r_fph;
  logic          r_ready;

  op_t           w_op;
  logic [1:0]    w_rd, w_rs1, w_rs2;
  logic [15:0]   w_a, w_b, w_sd, w_mrd, w_alu, w_wd;
  logic signed [15:0] w_quo;
  logic [AW-1:0] w_ea, w_maddr;
  logic          w_halt, w_memop, w_rf_we, w_mem_we;

  assign w_op    = op_t'(r_ir[15:13]);
  assign w_rd    = r_ir[12:11];
  assign w_rs1   = r_ir[10:9];
  assign w_rs2   = r_ir[8:7];
  assign w_halt  = (r_ir == 16'h0000) || (w_op == OP_HALT);
  assign w_memop = (w_op == OP_LOAD) || (w_op == OP_STORE);
  assign w_ea    = w_a[AW-1:0] + r_ir[AW-1:0];
  assign ready   = r_ready;

  cpu_rf RF (
    .clk(clk), .reset(reset),
    .i_we(w_rf_we), .i_wa(w_rd), .i_wd(w_wd),
    .i_ra1(w_rs1), .i_ra2(w_rs2), .i_ra3(w_rd),
    .o_rd1(w_a), .o_rd2(w_b), .o_rd3(w_sd)
  );

  // Address is the PC while fetching, otherwise the latched effective address.
  assign w_maddr  = (r_state == S_FETCH) ? r_pc : r_ea;
  assign w_mem_we = reset && (r_state == S_MEM) && (w_op == OP_STORE);

  cpu_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) MEM (
    .clk(clk), .i_we(w_mem_we), .i_addr(w_maddr), .i_wd(w_sd), .o_rd(w_mrd)
  );

  assign w_rf_we = (r_state == S_WB) &&
                   (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_MUL ||
                    w_op == OP_DIV || w_op == OP_LOAD);
  assign w_wd    = (w_op == OP_LOAD) ? w_mrd : r_res;
  assign w_quo   = $signed(w_a) / $signed(w_b);

  // Low half of a product is sign-agnostic, so a 16-bit multiply suffices.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD: w_alu = w_a + w_b;
      OP_SUB: w_alu = w_a - w_b;
      OP_MUL: w_alu = w_a * w_b;
      OP_DIV: begin
        if (w_b == 16'h0000)                           w_alu = 16'hFFFF;
        else if (w_a == 16'h8000 && w_b == 16'hFFFF)   w_alu = 16'h8000;
        else                                           w_alu = w_quo;
      end
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ready <= 1'b0;
      r_fph   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pc    <= '0;
            r_ready <= 1'b0;
            r_fph   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        // Two cycles: present the PC, then capture the returned word.
        S_FETCH: begin
          if (!r_fph) begin
            r_fph <= 1'b1;
          end else begin
            r_fph   <= 1'b0;
            r_ir    <= w_mrd;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_pc <= r_pc + 1'b1;
          if (w_halt) begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_alu;
          r_ea    <= w_ea;
          r_state <= w_memop ? S_MEM : S_WB;
        end
        S_MEM:   r_state <= S_WB;
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random programs compared
// against an instruction-level reference model (registers, memory, cycle count).

module tb_cpu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready;

  cpu #(.MEM_DEPTH(512)) dut (.clk(clk), .reset(reset), .start(start), .ready(ready));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_mem [512];
  logic [15:0] m_x   [4];
  int          m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) m_mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++)   m_x[i] = 16'h0000;
  endtask

  task automatic preload();
    @(negedge clk);
    for (int i = 0; i < 512; i++) dut.MEM.memory[i[8:0]] <= m_mem[i];
    dut.RF.x1 <= m_x[1];
    dut.RF.x2 <= m_x[2];
    dut.RF.x3 <= m_x[3];
    #1;
  endtask

  // Instruction-level reference: executes the program straight from the rules.
  task automatic model_run();
    int pc, sa, sb, r, ea, op;
    logic [15:0] w;
    pc = 0;
    m_cyc = 3;
    for (int steps = 0; steps < 2000; steps++) begin
      w  = m_mem[pc];
      op = int'(w[15:13]);
      if (w == 16'h0000 || op == 7) break;
      pc = (pc + 1) % 512;
      sa = $signed(m_x[w[10:9]]);
      sb = $signed(m_x[w[8:7]]);
      ea = (int'(m_x[w[10:9]]) + int'(w[8:0])) % 512;
      r  = 0;
      case (op)
        0: r = sa + sb;
        1: r = sa - sb;
        2: r = sa * sb;
        3: r = (sb == 0) ? -1 : (sa == -32768 && sb == -1) ? -32768 : sa / sb;
        4: r = int'(m_mem[ea]);
        5: m_mem[ea] = m_x[w[12:11]];
        default: ;
      endcase
      if (op <= 4 && w[12:11] != 2'd0) m_x[w[12:11]] = r[15:0];
      m_cyc += (op == 4 || op == 5) ? 6 : 5;
    end
  endtask

  task automatic run_dut(input int hold);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_clr_on_start", {31'd0, ready}, 32'd0);
    if (hold == 0) start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == hold) start = 1'b0;
    end
    start = 1'b0;
    chk("latency", cyc, m_cyc);
    chk("ready_set", {31'd0, ready}, 32'd1);
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_x1", tag), {16'd0, dut.RF.x1}, {16'd0, m_x[1]});
    chk($sformatf("%s_x2", tag), {16'd0, dut.RF.x2}, {16'd0, m_x[2]});
    chk($sformatf("%s_x3", tag), {16'd0, dut.RF.x3}, {16'd0, m_x[3]});
    for (int i = 0; i < 512; i++)
      chk($sformatf("%s_m%0d", tag, i), {16'd0, dut.MEM.memory[i[8:0]]}, {16'd0, m_mem[i]});
  endtask

  task automatic run_test(input string tag, input int hold);
    preload();
    model_run();
    run_dut(hold);
    check_all(tag);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    int op;
    op = $urandom_range(0, 6);
    if (op == 5) return {3'd5, 2'($urandom), 2'd0, 9'($urandom_range(256, 511))};
    return {3'(op), 13'($urandom)};
  endfunction

  logic [15:0] arith_exp [3] = '{16'd14, 16'd6, 16'd40};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_x1", {16'd0, dut.RF.x1}, 32'd0);
    chk("rst_x2", {16'd0, dut.RF.x2}, 32'd0);
    chk("rst_x3", {16'd0, dut.RF.x3}, 32'd0);
    reset = 1'b1;

    // ADD / SUB / MUL with x2=10, x3=4
    for (int k = 0; k < 3; k++) begin
      clear_model();
      m_x[2] = 16'd10; m_x[3] = 16'd4;
      m_mem[0] = {3'(k), 2'd1, 2'd2, 2'd3, 7'd0};
      run_test($sformatf("arith%0d", k), 0);
      chk($sformatf("arith%0d_const", k), {16'd0, dut.RF.x1}, {16'd0, arith_exp[k]});
    end

    // DIV then STORE then LOAD
    clear_model();
    m_x[2] = 16'd10; m_x[3] = 16'd4;
    m_mem[0] = 16'b011_01_10_11_0000000;
    m_mem[1] = 16'b101_01_00_000000101;
    m_mem[2] = 16'b100_11_00_000000101;
    run_test("dsl", 0);
    chk("dsl_x1", {16'd0, dut.RF.x1}, 32'd2);
    chk("dsl_m5", {16'd0, dut.MEM.memory[5]}, 32'd2);
    chk("dsl_x3", {16'd0, dut.RF.x3}, 32'd2);

    // Signed DIV / MUL and divide by zero
    clear_model();
    m_x[2] = 16'hFFF9; m_x[3] = 16'd2;
    m_mem[0] = {3'd3, 2'd1, 2'd2, 2'd3, 7'd0};
    run_test("sdiv", 0);
    chk("sdiv_const", {16'd0, dut.RF.x1}, 32'h0000FFFD);
    m_mem[0] = {3'd2, 2'd1, 2'd2, 2'd3, 7'd0};
    m_x[1] = 16'd0;
    run_test("smul", 0);
    chk("smul_const", {16'd0, dut.RF.x1}, 32'h0000FFF2);
    m_mem[0] = {3'd3, 2'd1, 2'd2, 2'd3, 7'd0};
    m_x[1] = 16'd0; m_x[3] = 16'd0;
    run_test("div0", 0);
    chk("div0_const", {16'd0, dut.RF.x1}, 32'h0000FFFF);

    // Overflow quotient -32768 / -1
    clear_model();
    m_x[2] = 16'h8000; m_x[3] = 16'hFFFF;
    m_mem[0] = {3'd3, 2'd1, 2'd2, 2'd3, 7'd0};
    run_test("dovf", 0);
    chk("dovf_const", {16'd0, dut.RF.x1}, 32'h00008000);

    // Writes to x0 are discarded
    clear_model();
    m_x[2] = 16'd10; m_x[3] = 16'd4;
    m_mem[0] = {3'd0, 2'd0, 2'd2, 2'd3, 7'd0};
    m_mem[1] = {3'd5, 2'd0, 2'd0, 9'd5};
    m_mem[5] = 16'h5555;
    run_test("x0", 0);
    chk("x0_m5", {16'd0, dut.MEM.memory[5]}, 32'd0);

    // Address wrap: 510 + 3 -> 1
    clear_model();
    m_x[1] = 16'd510;
    m_mem[0] = {3'd4, 2'd2, 2'd1, 9'd3};
    m_mem[1] = 16'hC000;
    run_test("wrap", 0);
    chk("wrap_x2", {16'd0, dut.RF.x2}, 32'h0000C000);

    // start held high while running is ignored
    clear_model();
    m_x[2] = 16'd3; m_x[3] = 16'd5;
    m_mem[0] = {3'd0, 2'd1, 2'd2, 2'd3, 7'd0};
    m_mem[1] = 16'hC000;
    m_mem[2] = 16'hC000;
    m_mem[3] = {3'd1, 2'd3, 2'd1, 2'd2, 7'd0};
    run_test("hold", 6);

    // Reset while the first instruction is in EXEC
    clear_model();
    m_x[2] = 16'd7; m_x[3] = 16'd9;
    m_mem[0] = {3'd0, 2'd1, 2'd2, 2'd3, 7'd0};
    m_mem[1] = {3'd5, 2'd1, 2'd0, 9'd300};
    m_mem[300] = 16'hBEEF;
    preload();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_x1", {16'd0, dut.RF.x1}, 32'd0);
    chk("midrst_x2", {16'd0, dut.RF.x2}, 32'd0);
    chk("midrst_x3", {16'd0, dut.RF.x3}, 32'd0);
    chk("midrst_m300", {16'd0, dut.MEM.memory[300]}, 32'h0000BEEF);
    for (int i = 1; i < 4; i++) m_x[i] = 16'd0;
    model_run();
    run_dut(0);
    check_all("rerun");

    // Random programs
    for (int t = 0; t < 20; t++) begin
      int n;
      clear_model();
      for (int r = 1; r < 4; r++) m_x[r] = pick_val();
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) m_mem[k] = rand_instr();
      for (int a = 256; a < 512; a++) m_mem[a] = 16'($urandom);
      run_test($sformatf("rnd%0d", t), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end
endmodule
